// File: rtl/sample_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : sample_capture_if
//  Description : Read-side bundle of the sample capture FIFO. The capture
//                block is the master (drives data, valid and occupancy); the
//                host is the slave (drives rd_ready).
//  Signals     : rd_valid  FIFO non-empty, rd_data is valid
//                rd_data   FIFO head, first-word-fall-through
//                rd_ready  host accepts rd_data this cycle
//                level     current FIFO occupancy, 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
interface sample_capture_if #(
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 64
);
    localparam int c_LEVEL_BITS = $clog2(DEPTH) + 1;

    logic                    rd_valid;
    logic [DATA_BITS-1:0]    rd_data;
    logic                    rd_ready;
    logic [c_LEVEL_BITS-1:0] level;

    modport master (output rd_valid, output rd_data, output level, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input level, output rd_ready);
endinterface
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
//  Module      : sample_capture
//  Description : Captures a programmable number of filter output samples into
//                a first-word-fall-through FIFO. A delay line aligns the
//                sample strobe with the filter's output latency; a three-state
//                run controller decides which aligned strobes are written.
//  Ports       : clk, rst       clock, asynchronous active-high reset
//                clk_enable     global enable for the capture path
//                start          pulse arming a run (ignored while capturing)
//                capture_len    samples per run, latched on start
//                sample_strobe  a new sample enters the filter this cycle
//                filter_out     signed filter output sample
//                rd_if          FIFO read port (rd_valid/rd_data/rd_ready/level)
//                busy, done     run active / run complete
//                overflow       sticky: a sample was dropped on a full FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module sample_capture #(
    parameter int DATA_BITS = 16,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 64
) (
    input  wire                          clk,
    input  wire                          rst,
    input  wire                          clk_enable,
    input  wire                          start,
    input  wire        [15:0]            capture_len,
    input  wire                          sample_strobe,
    input  wire signed [DATA_BITS-1:0]   filter_out,
    sample_capture_if.master             rd_if,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow
);

    localparam int                      c_ADDR_BITS  = $clog2(DEPTH);
    localparam logic [c_ADDR_BITS:0]    c_FULL_LEVEL = (c_ADDR_BITS + 1)'(DEPTH);
    localparam logic [c_ADDR_BITS:0]    c_LEVEL_ONE  = (c_ADDR_BITS + 1)'(1);
    localparam logic [c_ADDR_BITS-1:0]  c_PTR_ONE    = c_ADDR_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_start_run;

    logic [LATENCY-1:0]       r_dly;
    logic                     w_cap_strobe;

    logic [15:0]              r_len;
    logic [15:0]              r_cnt;
    logic                     r_overflow;
    logic                     w_last;

    logic [DATA_BITS-1:0]     r_mem [DEPTH];
    logic [c_ADDR_BITS-1:0]   r_wr_ptr;
    logic [c_ADDR_BITS-1:0]   r_rd_ptr;
    logic [c_ADDR_BITS:0]     r_level;
    logic                     w_full;
    logic                     w_rd;
    logic                     w_wr_req;
    logic                     w_wr;
    logic                     w_drop;

    // ------------------------------------------------------------------------
    // Strobe delay line: advances only on enabled cycles so that a stalled
    // filter keeps its in-flight strobes aligned with its data.
    // ------------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_dly_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst)             r_dly <= '0;
                else if (clk_enable) r_dly <= sample_strobe;
            end
        end else begin : g_dly_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst)             r_dly <= '0;
                else if (clk_enable) r_dly <= {r_dly[LATENCY-2:0], sample_strobe};
            end
        end
    endgenerate

    assign w_cap_strobe = r_dly[LATENCY-1] & clk_enable;

    // ------------------------------------------------------------------------
    // FIFO handshake. A zero-length run never requests a write. A full FIFO
    // still accepts a write when the host pops in the same cycle.
    // ------------------------------------------------------------------------
    assign w_full   = (r_level == c_FULL_LEVEL);
    assign w_rd     = rd_if.rd_valid & rd_if.rd_ready;
    assign w_wr_req = (r_state == ST_CAPTURE) & w_cap_strobe & (r_len != 16'd0);
    assign w_wr     = w_wr_req & (~w_full | w_rd);
    assign w_drop   = w_wr_req & w_full & ~w_rd;
    // Dropped samples still count toward the run length.
    assign w_last   = ({1'b0, r_cnt} + 17'd1) == {1'b0, r_len};

    // ------------------------------------------------------------------------
    // Run controller
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next = ST_CAPTURE;
                    w_start_run  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (r_len == 16'd0)         w_state_next = ST_DONE;
                else if (w_wr_req & w_last) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else if (w_start_run) begin
            r_len      <= capture_len;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_req) r_cnt      <= r_cnt + 16'd1;
            if (w_drop)   r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // FIFO storage and pointers; power-of-two depth lets pointers wrap freely.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= filter_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_rd) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_LEVEL_ONE;
                2'b01:   r_level <= r_level - c_LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Head is masked while empty so reset presents rd_data = 0 even though
    // the storage array itself is not reset.
    assign rd_if.rd_valid = (r_level != '0);
    assign rd_if.rd_data  = rd_if.rd_valid ? r_mem[r_rd_ptr] : '0;
    assign rd_if.level    = r_level;

    assign busy     = (r_state == ST_CAPTURE);
    assign done     = (r_state == ST_DONE);
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/sample_capture.md
SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 SHALL have parameter DATA_BITS, default 16, width of the captured filter output sample.
REQ-002 SHALL have parameter DEPTH, default 64, FIFO entries; power of two, at least 4.
REQ-003 SHALL have parameter LATENCY, default 64, clock-enabled cycles from sample strobe to output capture; at least 1.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clk_enable  input  1  global enable for the capture path.
REQ-007 SHALL have port start  input  1  single-cycle pulse that arms a capture run.
REQ-008 SHALL have port capture_len  input  16  number of samples to capture, latched on start.
REQ-009 SHALL have port sample_strobe  input  1  marks the cycle a new sample enters the filter.
REQ-010 SHALL have port filter_out  input  DATA_BITS  signed filter output sample.
REQ-011 SHALL have port rd_ready  input  1  host accepts rd_data this cycle.
REQ-012 SHALL have port rd_valid  output  1  FIFO non-empty; rd_data is valid.
REQ-013 SHALL have port rd_data  output  DATA_BITS  FIFO head, first-word-fall-through.
REQ-014 SHALL have port level  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have ports busy, done, overflow  output  1 each  run active, run complete, sticky write-drop flag.

Function
REQ-016 SHALL implement a LATENCY-stage delay line of sample_strobe that shifts only when clk_enable=1; its last stage ANDed with clk_enable is cap_strobe.
REQ-017 SHALL implement FSM states IDLE, CAPTURE, DONE.
REQ-018 IDLE or DONE plus start=1 SHALL go to CAPTURE next cycle, latch capture_len, clear the sample counter, done and overflow; FIFO contents are kept.
REQ-019 start in CAPTURE SHALL be ignored.
REQ-020 In CAPTURE, each cap_strobe SHALL increment the sample counter and write filter_out into the FIFO if not full.
REQ-021 When the counter reaches the latched length, the FSM SHALL go to DONE on the same clock edge as the final write.
REQ-022 capture_len=0 SHALL take CAPTURE to DONE after one cycle with no writes.
REQ-023 A cap_strobe in IDLE or DONE SHALL be ignored.
REQ-024 busy SHALL be 1 exactly in CAPTURE; done SHALL be 1 exactly in DONE.
REQ-025 A cap_strobe in CAPTURE with the FIFO full and no read in the same cycle SHALL drop the sample, count it toward the length, and set overflow until the next start or reset.
REQ-026 Full FIFO with simultaneous read and write SHALL accept both; level is unchanged and overflow is not set.
REQ-027 Empty FIFO with a simultaneous write SHALL make rd_valid=1 the next cycle; no bypass in the same cycle.
REQ-028 A read SHALL occur when rd_valid and rd_ready are both 1; rd_ready with an empty FIFO SHALL have no effect.
REQ-029 The read port and level SHALL operate regardless of clk_enable and FSM state.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH; level SHALL range 0..DEPTH.
REQ-031 FIFO order SHALL be strict first-in first-out; rd_data SHALL equal filter_out exactly as sampled, with no truncation or sign change.

Reset
REQ-032 While rst=1, the circuit SHALL enter IDLE and clear the delay line, counter and pointers.
REQ-033 While rst=1, outputs SHALL be: rd_valid=0, level=0, busy=0, done=0, overflow=0, rd_data=0.
REQ-034 rst asserted mid-run SHALL abort the run, discard FIFO contents, and discard in-flight delay-line strobes.

Verification
REQ-035 Reset, then sample_strobe every 64 clocks with clk_enable=1 and no start -> level stays 0, busy=0.
REQ-036 Impulse: start with capture_len=4; filter_out=0x7FFF at the first cap_strobe, else 0 -> busy for 4 strobes, done=1, rd_data reads 0x7FFF,0,0,0.
REQ-037 Overflow: DEPTH=64, capture_len=70, rd_ready=0 -> level=64, overflow=1, done=1 after the 70th strobe, first 64 samples read back in order.
REQ-038 Full FIFO, rd_ready=1 during a cap_strobe -> level stays 64, overflow=0, new sample at the tail.
REQ-039 clk_enable=0 for 10 cycles right after a sample_strobe -> capture delayed by exactly 10 cycles.
REQ-040 rst pulse on the 3rd of 8 captures -> all outputs at reset values; later strobes write nothing until start.
